// File: rtl/partoserial_tx_pkg.sv
// partoserial_tx_pkg: symbol constants and state encoding shared by the serial link blocks
package partoserial_tx_pkg;
   localparam logic [7:0] SYM_COMMA = 8'hBC;
   localparam logic [7:0] SYM_IDLE  = 8'h7C;
   typedef enum logic [1:0] {ST_SYNC, ST_IDLE, ST_DATA} tx_state_t;
endpackage

// File: rtl/partoserial_tx_fifo.sv
// tx_fifo2: two-entry, 8-bit word buffer between the parallel port and the serializer
module tx_fifo2 (
   input  logic       clk_32f,
   input  logic       reset,
   input  logic       push,
   input  logic       pop,
   input  logic [7:0] din,
   output logic [7:0] dout,
   output logic       full,
   output logic       empty
);
   logic [7:0] mem [2];
   logic       wp, rp;
   logic [1:0] cnt;
   logic       do_push, do_pop;
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign full    = cnt == 2'd2;
   assign empty   = cnt == 2'd0;
   assign dout    = mem[rp];
   always_ff @(posedge clk_32f or posedge reset)
      if (reset) begin
         wp  <= 1'b0;
         rp  <= 1'b0;
         cnt <= 2'd0;
      end else begin
         if (do_push) wp <= ~wp;
         if (do_pop) rp <= ~rp;
         cnt <= cnt + {1'b0, do_push} - {1'b0, do_pop};
      end
   always_ff @(posedge clk_32f)
      if (do_push) mem[wp] <= din;
endmodule

// File: rtl/partoserial_tx.sv
// partoserial_tx: comma preamble, then FIFO words or idle symbols, shifted out MSB first
module partoserial_tx
   import partoserial_tx_pkg::*;
#(
   parameter int COMMA_COUNT = 4
) (
   input  logic       clk_32f,
   input  logic       reset,
   input  logic [7:0] data_in,
   input  logic       valid_in,
   output logic       ready_out,
   output logic       data_out,
   output logic [7:0] sym_out,
   output logic       sync_done
);
   localparam logic [7:0] CC_LAST = 8'(COMMA_COUNT);
   tx_state_t  state;
   logic [7:0] cc, sr, head, next_sym;
   logic [2:0] bit_cnt;
   logic       full, empty, bnd, decide, pop, push;
   assign bnd       = bit_cnt == 3'd7;
   // SYNC hands over to the normal load decision once the trailing 7C has gone out
   assign decide    = state != ST_SYNC || cc == CC_LAST;
   assign pop       = bnd && decide && !empty;
   assign ready_out = ~full & ~reset;
   assign push      = valid_in & ready_out;
   assign data_out  = sr[7];
   assign next_sym  = !decide ? (cc + 8'd1 == CC_LAST ? SYM_IDLE : SYM_COMMA) : empty ? SYM_IDLE : head;
   tx_fifo2 u_fifo (
      .clk_32f(clk_32f),
      .reset  (reset),
      .push   (push),
      .pop    (pop),
      .din    (data_in),
      .dout   (head),
      .full   (full),
      .empty  (empty)
   );
   always_ff @(posedge clk_32f or posedge reset)
      if (reset) begin
         state     <= ST_SYNC;
         cc        <= 8'd0;
         bit_cnt   <= 3'd0;
         sr        <= SYM_COMMA;
         sym_out   <= SYM_COMMA;
         sync_done <= 1'b0;
      end else begin
         bit_cnt <= bit_cnt + 3'd1;
         sr      <= {sr[6:0], 1'b0};
         if (bnd) begin
            sr      <= next_sym;
            sym_out <= next_sym;
            if (!decide) cc <= cc + 8'd1;
            else begin
               state     <= empty ? ST_IDLE : ST_DATA;
               sync_done <= 1'b1;
            end
         end
      end
endmodule

// File: tb/tb_partoserial_tx.sv
// tb_partoserial_tx: directed scenarios for preamble, buffering, ordering and reset abort
module tb_partoserial_tx;
   logic       clk_32f = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] data_in = 8'h00;
   logic       valid_in = 1'b0;
   logic       ready_out, data_out, sync_done;
   logic [7:0] sym_out;
   int         checks = 0;
   int         errors = 0;
   logic [2:0] bi;
   logic [7:0] rx = 8'h00;
   logic [7:0] q[$];
   partoserial_tx #(.COMMA_COUNT(4)) dut (
      .clk_32f  (clk_32f),
      .reset    (reset),
      .data_in  (data_in),
      .valid_in (valid_in),
      .ready_out(ready_out),
      .data_out (data_out),
      .sym_out  (sym_out),
      .sync_done(sync_done)
   );
   always #5 clk_32f = ~clk_32f;
   // bench framing: symbol boundaries every 8 edges from reset release
   always @(posedge clk_32f or posedge reset)
      if (reset) bi <= 3'd0;
      else bi <= bi + 3'd1;
   always @(negedge clk_32f)
      if (!reset) begin
         rx = {rx[6:0], data_out};
         if (bi == 3'd7) q.push_back(rx);
      end
   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk_32f);
   endtask
   task automatic release_reset();
      @(posedge clk_32f);
      #1 reset = 1'b0;
      q.delete();
      @(negedge clk_32f);
   endtask
   task automatic wait_syms(input int n);
      for (int i = 0; i < 400 && q.size() < n; i++) begin
         @(negedge clk_32f);
         #1;
      end
      if (q.size() < n) begin
         checks++;
         errors++;
         $display("FAIL sym_timeout got %0d symbols required %0d", q.size(), n);
      end
   endtask
   task automatic test_reset();
      do_reset();
      checks++; if (data_out !== 1'b1) begin errors++; $display("FAIL rst_data_out got %b exp 1", data_out); end
      checks++; if (ready_out !== 1'b0) begin errors++; $display("FAIL rst_ready got %b exp 0", ready_out); end
      checks++; if (sync_done !== 1'b0) begin errors++; $display("FAIL rst_sync_done got %b exp 0", sync_done); end
      checks++; if (sym_out !== 8'hBC) begin errors++; $display("FAIL rst_sym_out got %h exp bc", sym_out); end
   endtask
   task automatic test_preamble();
      release_reset();
      checks++; if (ready_out !== 1'b1) begin errors++; $display("FAIL pre_ready got %b exp 1", ready_out); end
      repeat (39) @(negedge clk_32f);
      checks++; if (sync_done !== 1'b0) begin errors++; $display("FAIL pre_sync39 got %b exp 0", sync_done); end
      @(negedge clk_32f);
      checks++; if (sync_done !== 1'b1) begin errors++; $display("FAIL pre_sync40 got %b exp 1", sync_done); end
      wait_syms(7);
      for (int i = 0; i < 7 && i < q.size(); i++) begin
         checks++;
         if (q[i] !== (i < 4 ? 8'hBC : 8'h7C)) begin errors++; $display("FAIL pre_sym%0d got %h exp %h", i, q[i], (i < 4 ? 8'hBC : 8'h7C)); end
      end
   endtask
   task automatic test_sync_fill();
      logic [7:0] exp [8] = '{8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'h7C, 8'hA5, 8'hA5, 8'h7C};
      do_reset();
      data_in = 8'hA5;
      valid_in = 1'b1;
      release_reset();
      repeat (2) @(negedge clk_32f);
      checks++; if (ready_out !== 1'b0) begin errors++; $display("FAIL fill_full got %b exp 0", ready_out); end
      repeat (8) @(negedge clk_32f);
      valid_in = 1'b0;
      repeat (29) @(negedge clk_32f);
      checks++; if (ready_out !== 1'b0) begin errors++; $display("FAIL fill_no_pop got %b exp 0", ready_out); end
      @(negedge clk_32f);
      checks++; if (ready_out !== 1'b1) begin errors++; $display("FAIL fill_popped got %b exp 1", ready_out); end
      wait_syms(8);
      for (int i = 0; i < 8 && i < q.size(); i++) begin
         checks++;
         if (q[i] !== exp[i]) begin errors++; $display("FAIL fill_sym%0d got %h exp %h", i, q[i], exp[i]); end
      end
   endtask
   task automatic test_back_to_back();
      logic [7:0] exp [5] = '{8'h7C, 8'h11, 8'h22, 8'h33, 8'h7C};
      do_reset();
      release_reset();
      repeat (41) @(negedge clk_32f);
      valid_in = 1'b1;
      data_in = 8'h11;
      @(negedge clk_32f);
      data_in = 8'h22;
      @(negedge clk_32f);
      checks++; if (ready_out !== 1'b0) begin errors++; $display("FAIL b2b_stall got %b exp 0", ready_out); end
      data_in = 8'h33;
      repeat (4) @(negedge clk_32f);
      checks++; if (ready_out !== 1'b0) begin errors++; $display("FAIL b2b_stall47 got %b exp 0", ready_out); end
      @(negedge clk_32f);
      checks++; if (ready_out !== 1'b1) begin errors++; $display("FAIL b2b_pop_edge_push got %b exp 1", ready_out); end
      @(negedge clk_32f);
      valid_in = 1'b0;
      checks++; if (ready_out !== 1'b0) begin errors++; $display("FAIL b2b_next_accept got %b exp 0", ready_out); end
      wait_syms(10);
      for (int i = 0; i < 5 && i + 5 < q.size(); i++) begin
         checks++;
         if (q[i+5] !== exp[i]) begin errors++; $display("FAIL b2b_sym%0d got %h exp %h", i + 5, q[i+5], exp[i]); end
      end
   endtask
   task automatic test_verbatim();
      logic [7:0] exp [4] = '{8'h7C, 8'hBC, 8'h7C, 8'h7C};
      valid_in = 1'b1;
      data_in = 8'hBC;
      @(negedge clk_32f);
      data_in = 8'h7C;
      @(negedge clk_32f);
      valid_in = 1'b0;
      q.delete();
      wait_syms(4);
      for (int i = 0; i < 4 && i < q.size(); i++) begin
         checks++;
         if (q[i] !== exp[i]) begin errors++; $display("FAIL verb_sym%0d got %h exp %h", i, q[i], exp[i]); end
      end
      checks++; if (sync_done !== 1'b1) begin errors++; $display("FAIL verb_sync got %b exp 1", sync_done); end
   endtask
   task automatic test_reset_mid();
      do_reset();
      release_reset();
      repeat (41) @(negedge clk_32f);
      valid_in = 1'b1;
      data_in = 8'h5A;
      @(negedge clk_32f);
      data_in = 8'hC3;
      @(negedge clk_32f);
      valid_in = 1'b0;
      repeat (8) @(negedge clk_32f);
      checks++; if (sym_out !== 8'h5A) begin errors++; $display("FAIL mid_sym got %h exp 5a", sym_out); end
      checks++; if (data_out !== 1'b1) begin errors++; $display("FAIL mid_bit got %b exp 1", data_out); end
      reset = 1'b1;
      #1;
      checks++; if (data_out !== 1'b1) begin errors++; $display("FAIL mid_rst_out got %b exp 1", data_out); end
      checks++; if (ready_out !== 1'b0) begin errors++; $display("FAIL mid_rst_ready got %b exp 0", ready_out); end
      checks++; if (sym_out !== 8'hBC) begin errors++; $display("FAIL mid_rst_sym got %h exp bc", sym_out); end
      checks++; if (sync_done !== 1'b0) begin errors++; $display("FAIL mid_rst_sync got %b exp 0", sync_done); end
      @(negedge clk_32f);
      release_reset();
      checks++; if (ready_out !== 1'b1) begin errors++; $display("FAIL mid_rel_ready got %b exp 1", ready_out); end
      wait_syms(7);
      for (int i = 0; i < 7 && i < q.size(); i++) begin
         checks++;
         if (q[i] !== (i < 4 ? 8'hBC : 8'h7C)) begin errors++; $display("FAIL mid_sym%0d got %h exp %h", i, q[i], (i < 4 ? 8'hBC : 8'h7C)); end
      end
   endtask
   initial begin
      test_reset();
      test_preamble();
      test_sync_fill();
      test_back_to_back();
      test_verbatim();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
